// File: rtl/sy_npu_mem_arb.sv
// Round-robin A-channel arbiter for NPU bus masters. An in-order owner FIFO
// records which requester issued each transaction so D responses route back to it.
module sy_npu_mem_arb #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned A_W       = 128,
  parameter int unsigned D_W       = 128,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_a_valid_i,
  output logic [NUM_REQ-1:0]     req_a_ready_o,
  input  logic [NUM_REQ*A_W-1:0] req_a_bits_i,
  input  logic [NUM_REQ-1:0]     req_a_last_i,
  output logic [NUM_REQ-1:0]     req_d_valid_o,
  input  logic [NUM_REQ-1:0]     req_d_ready_i,
  output logic [D_W-1:0]         req_d_bits_o,
  output logic                   mem_a_valid_o,
  input  logic                   mem_a_ready_i,
  output logic [A_W-1:0]         mem_a_bits_o,
  output logic                   mem_a_last_o,
  input  logic                   mem_d_valid_i,
  output logic                   mem_d_ready_o,
  input  logic [D_W-1:0]         mem_d_bits_i,
  input  logic                   mem_d_last_i,
  output logic                   busy_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {ST_IDLE, ST_BURST} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] fifo_mem_q [MAX_OUTST];

  logic [A_W-1:0]   a_bits_arr [NUM_REQ];
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic             in_burst;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             sel_valid;
  logic             sel_last;
  logic [A_W-1:0]   sel_bits;
  logic [IDX_W-1:0] head_idx;
  logic             head_ready;
  logic             fifo_empty;
  logic             fifo_full;
  logic             d_pop;
  logic             a_block;
  logic             a_take;
  logic             a_hs;
  logic             a_push;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign a_bits_arr[g] = req_a_bits_i[g*A_W +: A_W];
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Round-robin pick: first valid at or above rr_ptr, then wrap to the bottom.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_a_valid_i[k] && (IDX_W'(k) >= rr_ptr_q)) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(k);
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_a_valid_i[k]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(k);
      end
    end
  end

  assign in_burst = (state_q == ST_BURST);
  assign gnt_idx  = in_burst ? gnt_q : win_idx;
  assign gnt_vld  = in_burst | win_found;
  assign head_idx = fifo_mem_q[rd_ptr_q];

  always_comb begin
    sel_valid  = 1'b0;
    sel_last   = 1'b0;
    sel_bits   = '0;
    head_ready = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt_idx == IDX_W'(k)) begin
        sel_valid = req_a_valid_i[k];
        sel_last  = req_a_last_i[k];
        sel_bits  = a_bits_arr[k];
      end
      if (head_idx == IDX_W'(k)) begin
        head_ready = req_d_ready_i[k];
      end
    end
  end

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTST));

  assign mem_d_ready_o = rst_ni & ~fifo_empty & head_ready;
  assign d_pop         = mem_d_valid_i & mem_d_ready_o & mem_d_last_i;
  // A full FIFO only stalls new transactions when no slot frees up this cycle.
  assign a_block       = ~in_burst & fifo_full & ~d_pop;
  assign a_take        = rst_ni & gnt_vld & mem_a_ready_i & ~a_block;
  assign mem_a_valid_o = rst_ni & gnt_vld & sel_valid & ~a_block;
  assign mem_a_bits_o  = sel_bits;
  assign mem_a_last_o  = sel_last;
  assign a_hs          = mem_a_valid_o & mem_a_ready_i;
  assign a_push        = a_hs & ~in_burst;

  assign req_d_bits_o  = mem_d_bits_i;
  assign busy_o        = ~fifo_empty | in_burst;

  always_comb begin
    req_a_ready_o = '0;
    req_d_valid_o = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      req_a_ready_o[k] = a_take & (gnt_idx == IDX_W'(k));
      req_d_valid_o[k] = rst_ni & mem_d_valid_i & ~fifo_empty & (head_idx == IDX_W'(k));
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (a_hs) begin
      if (sel_last) begin
        state_d  = ST_IDLE;
        rr_ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end else begin
        state_d = ST_BURST;
        gnt_d   = gnt_idx;
      end
    end
    if (a_push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (d_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (a_push && !d_pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!a_push && d_pop) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < MAX_OUTST; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (a_push) begin
        fifo_mem_q[wr_ptr_q] <= gnt_idx;
      end
    end
  end

endmodule
